// File: rtl/wbs_uart_rx_fifo_if.sv
// Wishbone slave register port of the UART receive FIFO.
interface wbs_uart_rx_fifo_if;
    logic       wbs_stb_i;
    logic       wbs_we_i;
    logic [1:0] wbs_adr_i;
    logic [7:0] wbs_dat_i;
    logic [7:0] wbs_dat_o;
    logic       wbs_ack_o;

    modport master (
        output wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        input  wbs_dat_o, wbs_ack_o
    );

    modport slave (
        input  wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
        output wbs_dat_o, wbs_ack_o
    );
endinterface

// File: rtl/wbs_uart_rx_fifo.sv
// UART receive byte FIFO with a wishbone register port and a level/overflow interrupt.
module wbs_uart_rx_fifo #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned IRQ_LEVEL = 1
) (
    input  logic                      wbs_clk_i,
    input  logic                      wbs_rst_i,
    wbs_uart_rx_fifo_if.slave         wbs,
    input  logic [7:0]                rx_data_i,
    input  logic                      rx_valid_i,
    output logic                      irq_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = PW + 1;

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_LEVEL  = 2'd2;
    localparam logic [1:0] ADR_CTRL   = 2'd3;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          irq_en_q, irq_en_d;
    logic [7:0]    dat_q, dat_d;
    logic          ack_q, ack_d;
    logic          irq_q, irq_d;

    logic       acc, rd_acc, wr_acc;
    logic       empty, full;
    logic       pop, push, flush, ovf_set;
    logic [7:0] rd_val;
    logic       unused_dat;

    assign unused_dat = ^wbs.wbs_dat_i[7:3];

    // Transaction decode: a strobe is accepted only while no ack is outstanding.
    always_comb begin
        acc     = wbs.wbs_stb_i & ~ack_q;
        rd_acc  = acc & ~wbs.wbs_we_i;
        wr_acc  = acc &  wbs.wbs_we_i;
        empty   = (level_q == '0);
        full    = (level_q == LW'(DEPTH));
        pop     = rd_acc & (wbs.wbs_adr_i == ADR_DATA) & ~empty;
        flush   = wr_acc & (wbs.wbs_adr_i == ADR_CTRL) & wbs.wbs_dat_i[1];
        // A pop on the same edge frees the slot, so a full FIFO still takes the byte.
        push    = rx_valid_i & (~full | pop) & ~flush;
        ovf_set = rx_valid_i & full & ~pop & ~flush;
    end

    always_comb begin
        rd_val = 8'h00;
        case (wbs.wbs_adr_i)
            ADR_DATA:   rd_val = empty ? 8'h00 : mem_q[rd_ptr_q];
            ADR_STATUS: rd_val = {4'b0000, irq_q, ovf_q, full, ~empty};
            ADR_LEVEL:  rd_val = 8'(level_q);
            ADR_CTRL:   rd_val = {7'b0000000, irq_en_q};
            default:    rd_val = 8'h00;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        irq_en_d = irq_en_q;
        dat_d    = dat_q;
        ack_d    = acc;
        irq_d    = 1'b0;

        if (rd_acc) begin
            dat_d = rd_val;
        end
        if (wr_acc && wbs.wbs_adr_i == ADR_STATUS && wbs.wbs_dat_i[2]) begin
            ovf_d = 1'b0;
        end
        if (wr_acc && wbs.wbs_adr_i == ADR_CTRL) begin
            irq_en_d = wbs.wbs_dat_i[0];
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        level_d = level_q + LW'(push) - LW'(pop);
        if (ovf_set) begin
            ovf_d = 1'b1;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end

        irq_d = irq_en_d & ((level_d >= LW'(IRQ_LEVEL)) | ovf_d);
    end

    always_ff @(posedge wbs_clk_i) begin
        if (wbs_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            dat_q    <= 8'h00;
            ack_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            dat_q    <= dat_d;
            ack_q    <= ack_d;
            irq_q    <= irq_d;
        end
    end

    // Storage is not reset; a slot is only readable after it has been written.
    always_ff @(posedge wbs_clk_i) begin
        if (push && !wbs_rst_i) begin
            mem_q[wr_ptr_q] <= rx_data_i;
        end
    end

    assign wbs.wbs_dat_o = dat_q;
    assign wbs.wbs_ack_o = ack_q;
    assign irq_o         = irq_q;

endmodule

// File: tb/tb_wbs_uart_rx_fifo.sv
// Directed testbench for wbs_uart_rx_fifo (DEPTH=16, IRQ_LEVEL=1).
module tb_wbs_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       irq;
    int         vec  = 0;
    int         errs = 0;

    localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_LEVEL = 2'd2, A_CTRL = 2'd3;

    wbs_uart_rx_fifo_if bus ();

    wbs_uart_rx_fifo #(.DEPTH(16), .IRQ_LEVEL(1)) dut (
        .wbs_clk_i  (clk),
        .wbs_rst_i  (rst),
        .wbs        (bus),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // One bus transaction, starting and ending on a falling edge; returns wbs_dat_o at the ack.
    task automatic bus_xfer(input logic we, input logic [1:0] adr, input logic [7:0] wd,
                            output logic [7:0] rd);
        bit got = 1'b0;
        rd = 8'h00;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = wd;
        bus.wbs_stb_i = 1'b1;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus.wbs_ack_o === 1'b1) begin
                got = 1'b1;
                rd  = bus.wbs_dat_o;
            end
        end
        vec++;
        if (!got) begin
            errs++;
            $display("FAIL ack_timeout adr=%0d: no ack seen, required ack within 4 cycles", adr);
        end
        @(negedge clk);
        bus.wbs_stb_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] adr, output logic [7:0] d);
        bus_xfer(1'b0, adr, 8'h00, d);
    endtask

    task automatic wr(input logic [1:0] adr, input logic [7:0] v);
        logic [7:0] d;
        bus_xfer(1'b1, adr, v, d);
    endtask

    task automatic test_reset;
        logic [7:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vec++; if (bus.wbs_ack_o !== 1'b0) begin errs++; $display("FAIL rst_ack got %b exp 0", bus.wbs_ack_o); end
        vec++; if (bus.wbs_dat_o !== 8'h00) begin errs++; $display("FAIL rst_dat got %h exp 00", bus.wbs_dat_o); end
        vec++; if (irq !== 1'b0) begin errs++; $display("FAIL rst_irq got %b exp 0", irq); end
        rd(A_LEVEL, d);
        vec++; if (d !== 8'h00) begin errs++; $display("FAIL rst_level got %h exp 00", d); end
        rd(A_STATUS, d);
        vec++; if (d !== 8'h00) begin errs++; $display("FAIL rst_status got %h exp 00", d); end
        rd(A_CTRL, d);
        vec++; if (d !== 8'h00) begin errs++; $display("FAIL rst_ctrl got %h exp 00", d); end
    endtask

    task automatic test_basic;
        logic [7:0] d;
        logic [7:0] exp_b [3] = '{8'h41, 8'h42, 8'h43};
        for (int i = 0; i < 3; i++) push(exp_b[i]);
        rd(A_LEVEL, d);
        vec++; if (d !== 8'h03) begin errs++; $display("FAIL basic_level got %h exp 03", d); end
        bus_xfer(1'b1, A_DATA, 8'hEE, d);
        vec++; if (d !== 8'h03) begin errs++; $display("FAIL write_holds_dat got %h exp 03", d); end
        rd(A_LEVEL, d);
        vec++; if (d !== 8'h03) begin errs++; $display("FAIL data_write_ignored got %h exp 03", d); end
        for (int i = 0; i < 3; i++) begin
            rd(A_DATA, d);
            vec++; if (d !== exp_b[i]) begin errs++; $display("FAIL basic_data%0d got %h exp %h", i, d, exp_b[i]); end
        end
        rd(A_DATA, d);
        vec++; if (d !== 8'h00) begin errs++; $display("FAIL empty_read got %h exp 00", d); end
        rd(A_LEVEL, d);
        vec++; if (d !== 8'h00) begin errs++; $display("FAIL basic_level_end got %h exp 00", d); end
    endtask

    task automatic test_overflow;
        logic [7:0] d;
        for (int i = 0; i < 17; i++) push(8'(i));
        rd(A_STATUS, d);
        vec++; if (d !== 8'h07) begin errs++; $display("FAIL ovf_status got %h exp 07", d); end
        rd(A_LEVEL, d);
        vec++; if (d !== 8'h10) begin errs++; $display("FAIL ovf_level got %h exp 10", d); end
        for (int i = 0; i < 16; i++) begin
            rd(A_DATA, d);
            vec++; if (d !== 8'(i)) begin errs++; $display("FAIL ovf_data%0d got %h exp %h", i, d, 8'(i)); end
        end
        rd(A_STATUS, d);
        vec++; if (d !== 8'h04) begin errs++; $display("FAIL ovf_sticky got %h exp 04", d); end
        wr(A_STATUS, 8'h04);
        rd(A_STATUS, d);
        vec++; if (d !== 8'h00) begin errs++; $display("FAIL ovf_clear got %h exp 00", d); end
    endtask

    task automatic test_full_push_pop;
        logic [7:0] d;
        logic [7:0] e;
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
        rd(A_STATUS, d);
        vec++; if (d !== 8'h03) begin errs++; $display("FAIL full_status got %h exp 03", d); end
        bus.wbs_we_i = 1'b0; bus.wbs_adr_i = A_DATA; bus.wbs_stb_i = 1'b1;
        rx_data = 8'hA5; rx_valid = 1'b1;
        @(posedge clk); #1;
        vec++; if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== 8'h80) begin
            errs++; $display("FAIL full_pushpop ack=%b dat=%h exp ack=1 dat=80", bus.wbs_ack_o, bus.wbs_dat_o); end
        @(negedge clk); bus.wbs_stb_i = 1'b0; rx_valid = 1'b0;
        @(negedge clk);
        rd(A_LEVEL, d);
        vec++; if (d !== 8'h10) begin errs++; $display("FAIL full_pushpop_level got %h exp 10", d); end
        rd(A_STATUS, d);
        vec++; if (d !== 8'h03) begin errs++; $display("FAIL full_pushpop_noovf got %h exp 03", d); end
        for (int i = 0; i < 16; i++) begin
            e = (i < 15) ? 8'(8'h81 + i) : 8'hA5;
            rd(A_DATA, d);
            vec++; if (d !== e) begin errs++; $display("FAIL drain%0d got %h exp %h", i, d, e); end
        end
    endtask

    task automatic test_empty_push_pop;
        logic [7:0] d;
        bus.wbs_we_i = 1'b0; bus.wbs_adr_i = A_DATA; bus.wbs_stb_i = 1'b1;
        rx_data = 8'h66; rx_valid = 1'b1;
        @(posedge clk); #1;
        vec++; if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== 8'h00) begin
            errs++; $display("FAIL empty_pushpop ack=%b dat=%h exp ack=1 dat=00", bus.wbs_ack_o, bus.wbs_dat_o); end
        @(negedge clk); bus.wbs_stb_i = 1'b0; rx_valid = 1'b0;
        @(negedge clk);
        rd(A_LEVEL, d);
        vec++; if (d !== 8'h01) begin errs++; $display("FAIL empty_pushpop_level got %h exp 01", d); end
        rd(A_DATA, d);
        vec++; if (d !== 8'h66) begin errs++; $display("FAIL empty_pushpop_data got %h exp 66", d); end
    endtask

    task automatic test_irq;
        logic [7:0] d;
        wr(A_CTRL, 8'h01);
        vec++; if (irq !== 1'b0) begin errs++; $display("FAIL irq_idle got %b exp 0", irq); end
        push(8'h55);
        vec++; if (irq !== 1'b1) begin errs++; $display("FAIL irq_rise got %b exp 1", irq); end
        rd(A_STATUS, d);
        vec++; if (d !== 8'h09) begin errs++; $display("FAIL irq_status got %h exp 09", d); end
        rd(A_DATA, d);
        vec++; if (d !== 8'h55) begin errs++; $display("FAIL irq_data got %h exp 55", d); end
        vec++; if (irq !== 1'b0) begin errs++; $display("FAIL irq_fall got %b exp 0", irq); end
    endtask

    task automatic test_flush;
        logic [7:0] d;
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
        vec++; if (irq !== 1'b1) begin errs++; $display("FAIL flush_pre_irq got %b exp 1", irq); end
        bus.wbs_we_i = 1'b1; bus.wbs_adr_i = A_CTRL; bus.wbs_dat_i = 8'h03; bus.wbs_stb_i = 1'b1;
        rx_data = 8'h77; rx_valid = 1'b1;
        @(posedge clk); #1;
        vec++; if (bus.wbs_ack_o !== 1'b1) begin errs++; $display("FAIL flush_ack got %b exp 1", bus.wbs_ack_o); end
        @(negedge clk); bus.wbs_stb_i = 1'b0; rx_valid = 1'b0;
        @(negedge clk);
        rd(A_LEVEL, d);
        vec++; if (d !== 8'h00) begin errs++; $display("FAIL flush_level got %h exp 00", d); end
        rd(A_STATUS, d);
        vec++; if (d !== 8'h00) begin errs++; $display("FAIL flush_status got %h exp 00", d); end
        rd(A_CTRL, d);
        vec++; if (d !== 8'h01) begin errs++; $display("FAIL flush_ctrl got %h exp 01", d); end
        vec++; if (irq !== 1'b0) begin errs++; $display("FAIL flush_irq got %b exp 0", irq); end
    endtask

    task automatic test_back_to_back;
        logic exp_ack;
        bus.wbs_we_i = 1'b0; bus.wbs_adr_i = A_LEVEL; bus.wbs_stb_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            exp_ack = (i % 2 == 0);
            vec++; if (bus.wbs_ack_o !== exp_ack) begin
                errs++; $display("FAIL b2b_ack%0d got %b exp %b", i, bus.wbs_ack_o, exp_ack); end
        end
        @(negedge clk); bus.wbs_stb_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
        vec++; if (irq !== 1'b1) begin errs++; $display("FAIL rstmid_pre_irq got %b exp 1", irq); end
        bus.wbs_we_i = 1'b0; bus.wbs_adr_i = A_DATA; bus.wbs_stb_i = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        vec++; if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 8'h00 || irq !== 1'b0) begin
            errs++; $display("FAIL rstmid ack=%b dat=%h irq=%b exp 0/00/0", bus.wbs_ack_o, bus.wbs_dat_o, irq); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        vec++; if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== 8'h00) begin
            errs++; $display("FAIL rstmid_new_txn ack=%b dat=%h exp 1/00", bus.wbs_ack_o, bus.wbs_dat_o); end
        @(negedge clk); bus.wbs_stb_i = 1'b0;
        @(negedge clk);
        rd(A_LEVEL, d);
        vec++; if (d !== 8'h00) begin errs++; $display("FAIL rstmid_level got %h exp 00", d); end
        rd(A_CTRL, d);
        vec++; if (d !== 8'h00) begin errs++; $display("FAIL rstmid_ctrl got %h exp 00", d); end
    endtask

    initial begin
        rst           = 1'b1;
        rx_data       = 8'h00;
        rx_valid      = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = 2'd0;
        bus.wbs_dat_i = 8'h00;
        @(negedge clk);
        test_reset;
        test_basic;
        test_overflow;
        test_full_push_pop;
        test_empty_push_pop;
        test_irq;
        test_flush;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
